// File: rtl/bird_frame_sequencer_if.sv
// Handshake bundle between the frame sequencer, game logic, bird drawer and framebuffer.
// master = environment side (game/drawer), slave = sequencer.
interface bird_frame_sequencer_if #(
    parameter int COLOR_W = 1
);
    logic               frame_tick;
    logic [10:0]        bird_x;
    logic [10:0]        bird_y;
    logic               draw_start;
    logic [10:0]        draw_x;
    logic [10:0]        draw_y;
    logic               draw_done;
    logic [10:0]        pix_x;
    logic [10:0]        pix_y;
    logic [10:0]        fb_x;
    logic [10:0]        fb_y;
    logic [COLOR_W-1:0] fb_color;
    logic               fb_we;

    modport master (
        output frame_tick, bird_x, bird_y, draw_done, pix_x, pix_y,
        input  draw_start, draw_x, draw_y, fb_x, fb_y, fb_color, fb_we
    );

    modport slave (
        input  frame_tick, bird_x, bird_y, draw_done, pix_x, pix_y,
        output draw_start, draw_x, draw_y, fb_x, fb_y, fb_color, fb_we
    );
endinterface

// File: rtl/bird_frame_sequencer.sv
// Per-frame erase/draw sequencer for the bird sprite drawer.
// Optional BIRD_FRAME_SEQ_SKIP_STILL_EN: skip both passes when the bird has not moved.
module bird_frame_sequencer #(
    parameter int                 COLOR_W  = 1,
    parameter logic [COLOR_W-1:0] BG_COLOR = '0,
    parameter logic [COLOR_W-1:0] FG_COLOR = COLOR_W'(1)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    bird_frame_sequencer_if.slave   bus,
    output logic                    busy_o,
    output logic                    frame_done_o,
    output logic                    overrun_o
);
    typedef enum logic [2:0] {
        IDLE, ERASE_RUN, ERASE_REL, DRAW_RUN, DRAW_REL, FIN
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [10:0] old_x_q, old_x_d, old_y_q, old_y_d;
    logic        old_valid_q, old_valid_d;
    logic        overrun_q, overrun_d;
    logic [1:0]  arm_pipe_q, arm_pipe_d;
    logic        run;
    logic        skip_still;
    logic [COLOR_W-1:0] color;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            old_x_q     <= '0;
            old_y_q     <= '0;
            old_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            arm_pipe_q  <= '0;
        end else begin
            state_q     <= state_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            old_x_q     <= old_x_d;
            old_y_q     <= old_y_d;
            old_valid_q <= old_valid_d;
            overrun_q   <= overrun_d;
            arm_pipe_q  <= arm_pipe_d;
        end
    end

`ifdef BIRD_FRAME_SEQ_SKIP_STILL_EN
    assign skip_still = old_valid_q && (bus.bird_x == old_x_q) && (bus.bird_y == old_y_q);
`else
    assign skip_still = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        cur_x_d        = cur_x_q;
        cur_y_d        = cur_y_q;
        old_x_d        = old_x_q;
        old_y_d        = old_y_q;
        old_valid_d    = old_valid_q;
        overrun_d      = overrun_q | (bus.frame_tick && (state_q != IDLE));
        bus.draw_start = 1'b0;
        bus.draw_x     = '0;
        bus.draw_y     = '0;
        color          = '0;
        run            = 1'b0;
        frame_done_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.frame_tick) begin
                    cur_x_d = bus.bird_x;
                    cur_y_d = bus.bird_y;
                    if (skip_still)       state_d = FIN;
                    else if (old_valid_q) state_d = ERASE_RUN;
                    else                  state_d = DRAW_RUN;
                end
            end
            ERASE_RUN: begin
                bus.draw_start = 1'b1;
                bus.draw_x     = old_x_q;
                bus.draw_y     = old_y_q;
                color          = BG_COLOR;
                run            = 1'b1;
                if (bus.draw_done) state_d = ERASE_REL;
            end
            ERASE_REL: begin
                bus.draw_x = old_x_q;
                bus.draw_y = old_y_q;
                if (!bus.draw_done) state_d = DRAW_RUN;
            end
            DRAW_RUN: begin
                bus.draw_start = 1'b1;
                bus.draw_x     = cur_x_q;
                bus.draw_y     = cur_y_q;
                color          = FG_COLOR;
                run            = 1'b1;
                if (bus.draw_done) state_d = DRAW_REL;
            end
            DRAW_REL: begin
                bus.draw_x = cur_x_q;
                bus.draw_y = cur_y_q;
                if (!bus.draw_done) state_d = FIN;
            end
            FIN: begin
                old_x_d      = cur_x_q;
                old_y_d      = cur_y_q;
                old_valid_d  = 1'b1;
                frame_done_o = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Two-deep arm delay: the drawer spends one cycle latching the start before its
        // pixel outputs are meaningful, so writes begin two cycles into a RUN state.
        arm_pipe_d = (run && (state_d == state_q)) ? {arm_pipe_q[0], 1'b1} : 2'b00;
    end

    assign bus.fb_we    = run && arm_pipe_q[1] && !bus.draw_done;
    assign bus.fb_x     = bus.fb_we ? bus.pix_x : '0;
    assign bus.fb_y     = bus.fb_we ? bus.pix_y : '0;
    assign bus.fb_color = color;
    assign busy_o       = (state_q != IDLE);
    assign overrun_o    = overrun_q;
endmodule

// File: tb/tb_bird_frame_sequencer.sv
// Bench for bird_frame_sequencer: drawer model, write scoreboard, table rows, reset
// corner cases and randomized frames.
module tb_bird_frame_sequencer;
    localparam int CW = 1;
    localparam logic [CW-1:0] BG = 1'b0;
    localparam logic [CW-1:0] FG = 1'b1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy, frame_done, overrun;
    always #5 clk = ~clk;

    bird_frame_sequencer_if #(.COLOR_W(CW)) bus();

    bird_frame_sequencer #(.COLOR_W(CW), .BG_COLOR(BG), .FG_COLOR(FG)) dut (
        .clk_i(clk), .reset_i(reset), .bus(bus),
        .busy_o(busy), .frame_done_o(frame_done), .overrun_o(overrun)
    );

    // Drawer model: idle -> one setup cycle -> npix pixels (4 wide) -> done, holding
    // done until start drops plus extra_hold cycles.
    int dst, didx, dhold;
    logic [10:0] dax, day;
    int npix = 8;
    int extra_hold = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            dst <= 0; didx <= 0; dhold <= 0; dax <= '0; day <= '0;
        end else begin
            case (dst)
                0: if (bus.draw_start) begin dax <= bus.draw_x; day <= bus.draw_y; dst <= 1; end
                1: begin dst <= 2; didx <= 0; end
                2: if (didx == npix - 1) begin dst <= 3; dhold <= extra_hold; end
                   else didx <= didx + 1;
                3: if (!bus.draw_start) begin
                       if (dhold == 0) dst <= 0;
                       else dhold <= dhold - 1;
                   end
                default: dst <= 0;
            endcase
        end
    end

    always_comb begin
        bus.draw_done = (dst == 3);
        bus.pix_x = 11'h7ff;
        bus.pix_y = 11'h7ff;
        if (dst == 2) begin
            bus.pix_x = dax + 11'(didx % 4);
            bus.pix_y = day + 11'(didx / 4);
        end
    end

    // Monitor: logs every framebuffer write and protocol anomalies.
    typedef logic [22+CW-1:0] wr_t;   // {x, y, color}
    wr_t wq[$];
    int starts = 0, start_in_done = 0, rel_we = 0, lat_err = 0, gate_err = 0;
    int tcyc = 0, rise_cyc = 0;
    logic first_pend = 1'b0, prev_ds = 1'b0;

    always @(negedge clk) begin
        tcyc <= tcyc + 1;
        prev_ds <= bus.draw_start;
        if (!reset) begin
            if (bus.draw_start && !prev_ds) begin
                starts <= starts + 1;
                if (bus.draw_done) start_in_done <= start_in_done + 1;
                rise_cyc <= tcyc;
                first_pend <= 1'b1;
            end
            if (bus.fb_we) begin
                wq.push_back({bus.fb_x, bus.fb_y, bus.fb_color});
                if (!bus.draw_start || bus.draw_done) rel_we <= rel_we + 1;
                if (first_pend) begin
                    if (tcyc - rise_cyc != 2) lat_err <= lat_err + 1;
                    first_pend <= 1'b0;
                end
            end else if (bus.fb_x != 0 || bus.fb_y != 0) begin
                gate_err <= gate_err + 1;
            end
        end
    end

    int vec = 0, errs = 0;
    task automatic chk(input string nm, input longint act, input longint req);
        vec++;
        if (act != req) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", nm, act, req);
        end
    endtask

    // Reference model: what the framebuffer should see for a frame.
    logic [10:0] m_old_x = '0, m_old_y = '0;
    bit m_valid = 0, m_ovr = 0;
    wr_t exp_q[$];

    function automatic void push_sprite(logic [10:0] ax, logic [10:0] ay, logic [CW-1:0] c, int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({ax + 11'(i % 4), ay + 11'(i / 4), c});
    endfunction

    task automatic run_frame(input logic [10:0] x, input logic [10:0] y, input int np,
                             input int hold, input int ov_at, input bit erase);
        int base, s0, sd0, rw0, le0, ge0, cyc, exp_starts, mism;
        bit skip;
        logic [10:0] a0x;
        skip = 0;
`ifdef BIRD_FRAME_SEQ_SKIP_STILL_EN
        skip = m_valid && x == m_old_x && y == m_old_y;
`endif
        exp_q.delete();
        if (!skip) begin
            if (erase) push_sprite(m_old_x, m_old_y, BG, np);
            push_sprite(x, y, FG, np);
        end
        exp_starts = skip ? 0 : (erase ? 2 : 1);
        a0x = erase ? m_old_x : x;
        if (ov_at > 0) m_ovr = 1;
        npix = np; extra_hold = hold;
        base = wq.size(); s0 = starts; sd0 = start_in_done; rw0 = rel_we; le0 = lat_err; ge0 = gate_err;

        @(negedge clk);
        bus.frame_tick = 1'b1; bus.bird_x = x; bus.bird_y = y;
        @(negedge clk);
        bus.frame_tick = 1'b0; bus.bird_x = 11'($urandom); bus.bird_y = 11'($urandom);
        cyc = 1;
        chk("start_latency", bus.draw_start, !skip);
        if (!skip) chk("first_anchor_x", bus.draw_x, a0x);
        while (cyc < 600) begin
            if (frame_done) break;
            bus.frame_tick = (cyc == ov_at);
            if (cyc == ov_at) bus.bird_x = x ^ 11'h155;
            @(negedge clk);
            cyc++;
        end
        bus.frame_tick = 1'b0;
        if (!frame_done) begin
            chk("frame_done_timeout", 0, 1);
        end else begin
            chk("busy_at_done", busy, 1);
            if (skip) chk("skip_done_latency", cyc, 1);
            @(negedge clk);
            chk("done_pulse_len", frame_done, 0);
            chk("busy_after_done", busy, 0);
        end
        chk("write_count", wq.size() - base, exp_q.size());
        mism = 0;
        for (int i = 0; i < exp_q.size() && base + i < wq.size(); i++)
            if (wq[base + i] != exp_q[i]) mism++;
        chk("write_data", mism, 0);
        chk("start_count", starts - s0, exp_starts);
        chk("start_while_done", start_in_done - sd0, 0);
        chk("we_outside_run", rel_we - rw0, 0);
        chk("we_latency", lat_err - le0, 0);
        chk("fb_addr_gate", gate_err - ge0, 0);
        chk("overrun", overrun, m_ovr);
        m_old_x = x; m_old_y = y; m_valid = 1;
    endtask

    typedef struct {
        logic [10:0] x, y;
        int np, hold, ov_at;
        bit erase;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int k;
        bit found;
        logic [10:0] rx, ry;
        tbl[0] = '{11'd100,  11'd100,  8,  0, -1, 1'b0};
        tbl[1] = '{11'd104,  11'd100,  8,  0, -1, 1'b1};
        tbl[2] = '{11'd200,  11'd50,   5,  3, -1, 1'b1};
        tbl[3] = '{11'd210,  11'd60,   12, 0,  6, 1'b1};
        tbl[4] = '{11'd0,    11'd0,    1,  1, -1, 1'b1};
        tbl[5] = '{11'd2047, 11'd2047, 9,  2, -1, 1'b1};

        bus.frame_tick = 1'b0; bus.bird_x = '0; bus.bird_y = '0;
        @(negedge clk); @(negedge clk);
        chk("reset_outputs", {bus.draw_start, bus.fb_we, busy, frame_done, overrun,
            |bus.draw_x, |bus.draw_y, |bus.fb_x, |bus.fb_y, |bus.fb_color}, 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++)
            run_frame(tbl[i].x, tbl[i].y, tbl[i].np, tbl[i].hold, tbl[i].ov_at, tbl[i].erase);

        // Reset asserted while the draw pass is writing.
        npix = 8; extra_hold = 0;
        @(negedge clk);
        bus.frame_tick = 1'b1; bus.bird_x = 11'd300; bus.bird_y = 11'd400;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        found = 0;
        for (k = 0; k < 300 && !found; k++) begin
            if (bus.draw_start && bus.fb_we && bus.draw_x == 11'd300) found = 1;
            else @(negedge clk);
        end
        chk("reach_draw_run", found, 1);
        reset = 1'b1;
        #1;
        chk("reset_mid_outputs", {bus.draw_start, bus.fb_we, busy, frame_done, overrun,
            |bus.draw_x, |bus.draw_y, |bus.fb_x, |bus.fb_y, |bus.fb_color}, 0);
        @(negedge clk);
        reset = 1'b0;
        m_valid = 0; m_ovr = 0; m_old_x = '0; m_old_y = '0;
        run_frame(11'd50, 11'd60, 6, 0, -1, 1'b0);
        run_frame(11'd50, 11'd60, 6, 0, -1, 1'b1);

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(3) == 0) begin rx = m_old_x; ry = m_old_y; end
            else begin rx = 11'($urandom); ry = 11'($urandom); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_frame(rx, ry, $urandom_range(1, 10), $urandom_range(0, 3), -1, m_valid);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
